// File: rtl/booth_multi_iter.sv
// booth_multi_iter: iterative radix-4 Booth multiplier. Each MUL cycle multiplies one
//   MW-bit chunk of the multiplicand into a shared accumulator.
// Latency: NCHUNK cycles from the input handshake to out_valid, or NCHUNK+1 when
//   BOOTH_PIPE_REG_EN is defined. That macro adds a register between the partial-product
//   array and the accumulator adder.
// Backpressure: the result is held in DONE while out_ready=0. in_ready is high in IDLE,
//   or in DONE when out_ready is high, so a new operation can issue as a result drains.
// Ports: clk/rstn (async active-low); in_valid/in_ready with multiplier[MW] and
//   multiplicand[MW*NCHUNK]; out_valid/out_ready with product[MW*(NCHUNK+1)]; busy.
module booth_multi_iter #(
    parameter int MW     = 16,
    parameter int NCHUNK = 2
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [MW-1:0]              multiplier,
    input  logic [MW*NCHUNK-1:0]       multiplicand,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [MW*(NCHUNK+1)-1:0]   product,
    output logic                       busy
);

    localparam int W    = MW * NCHUNK;
    localparam int ACCW = MW * (NCHUNK + 1);
    localparam int PPW  = 2 * MW;
    // The counter must be able to hold NCHUNK, which marks that generation has finished.
    localparam int KW   = (NCHUNK + 1 > 2) ? $clog2(NCHUNK + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [ACCW-1:0] acc_q, acc_d;
    logic [MW-1:0]   mult_q;
    logic [W-1:0]    mcand_q;

    logic            hs;
    logic            gen_en;
    logic [KW-1:0]   ksel;
    logic [MW-1:0]   chunk;
    logic [MW+2:0]   ext;
    logic [2:0]      trip;
    logic [PPW-1:0]  mag;
    logic            neg;
    logic [PPW-1:0]  pp;
    logic [PPW-1:0]  acc_pp;
    logic [KW-1:0]   acc_k;
    logic            acc_en;
    logic            last;

    assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign hs        = in_valid && in_ready;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign product   = (state_q == S_DONE) ? acc_q : '0;

    // Clamp the chunk index. In the pipelined build, k can reach NCHUNK while the last
    // partial product is still draining.
    assign ksel  = (k_q < KW'(NCHUNK)) ? k_q : '0;
    assign chunk = mcand_q[int'(ksel)*MW +: MW];

    // Radix-4 Booth recoding of the zero-extended multiplier: MW/2+1 digits in {-2..+2}.
    // The sum is taken modulo 2^(2*MW). That equals building it in 2*MW+2 bits and
    // truncating, and it is exact because an unsigned MW x MW product fits in 2*MW bits.
    always_comb begin
        ext  = {2'b00, mult_q, 1'b0};
        pp   = '0;
        trip = '0;
        mag  = '0;
        neg  = 1'b0;
        for (int i = 0; i <= MW/2; i++) begin
            trip = ext[2*i +: 3];
            mag  = '0;
            neg  = 1'b0;
            case (trip)
                3'b001, 3'b010: mag = PPW'(chunk);
                3'b011:         mag = PPW'(chunk) << 1;
                3'b100: begin   mag = PPW'(chunk) << 1; neg = 1'b1; end
                3'b101, 3'b110: begin mag = PPW'(chunk); neg = 1'b1; end
                default:        mag = '0;
            endcase
            pp = pp + ((neg ? -mag : mag) << (2*i));
        end
    end

`ifdef BOOTH_PIPE_REG_EN
    logic [PPW-1:0] pp_q;
    logic [KW-1:0]  pp_k_q;
    logic           pp_vld_q;

    // Generation runs for NCHUNK cycles. The adder works one cycle behind on the
    // registered partial product.
    assign gen_en = (state_q == S_MUL) && (k_q != KW'(NCHUNK));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pp_q     <= '0;
            pp_k_q   <= '0;
            pp_vld_q <= 1'b0;
        end else begin
            pp_q     <= pp;
            pp_k_q   <= k_q;
            pp_vld_q <= gen_en;
        end
    end

    assign acc_pp = pp_q;
    assign acc_k  = pp_k_q;
    assign acc_en = pp_vld_q;
`else
    assign gen_en = (state_q == S_MUL);
    assign acc_pp = pp;
    assign acc_k  = k_q;
    assign acc_en = gen_en;
`endif

    assign last = acc_en && (acc_k == KW'(NCHUNK - 1));

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        acc_d   = acc_q;
        if (gen_en) begin
            k_d = k_q + 1'b1;
        end
        if (acc_en) begin
            acc_d = acc_q + (ACCW'(acc_pp) << (int'(acc_k) * MW));
        end
        case (state_q)
            S_IDLE: if (hs) state_d = S_MUL;
            S_MUL:  if (last) state_d = S_DONE;
            S_DONE: if (out_ready) state_d = in_valid ? S_MUL : S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // A new operation starts from a clean accumulator and chunk 0.
        if (hs) begin
            k_d   = '0;
            acc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            acc_q   <= '0;
            mult_q  <= '0;
            mcand_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            if (hs) begin
                mult_q  <= multiplier;
                mcand_q <= multiplicand;
            end
        end
    end

endmodule

// File: tb/tb_booth_multi_iter.sv
module tb_booth_multi_iter;

    localparam int MW     = 16;
    localparam int NCHUNK = 2;
    localparam int W      = MW * NCHUNK;
    localparam int PW     = MW * (NCHUNK + 1);
`ifdef BOOTH_PIPE_REG_EN
    localparam int LAT = NCHUNK + 1;
`else
    localparam int LAT = NCHUNK;
`endif

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [MW-1:0] multiplier = '0;
    logic [W-1:0]  multiplicand = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [PW-1:0] product;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    logic [MW-1:0] bm [3];
    logic [W-1:0]  bc [3];
    logic [PW-1:0] be [3];

    always #5 clk = ~clk;

    booth_multi_iter #(.MW(MW), .NCHUNK(NCHUNK)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .multiplier   (multiplier),
        .multiplicand (multiplicand),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product),
        .busy         (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present operands until accepted, then scramble the inputs to prove they were latched.
    task automatic issue(input logic [MW-1:0] m, input logic [W-1:0] mc);
        int n = 0;
        multiplier   = m;
        multiplicand = mc;
        in_valid     = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("issue_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid     = 1'b0;
        multiplier   = MW'($urandom);
        multiplicand = W'($urandom);
    endtask

    task automatic wait_valid(input string tag);
        int lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk(tag, 64'(lat), 64'(LAT));
    endtask

    task automatic run_op(input string tag, input logic [MW-1:0] m, input logic [W-1:0] mc,
                          input logic [PW-1:0] exp);
        issue(m, mc);
        wait_valid({tag, "_lat"});
        chk({tag, "_prod"}, 64'(product), 64'(exp));
        @(posedge clk); #1;
        chk({tag, "_drained"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_product",   64'(product),   64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Full-scale operands, with busy and in_ready checked along the way.
        issue(16'hFFFF, 32'hFFFF_FFFF);
        chk("max_busy", 64'(busy), 64'd1);
        chk("max_in_ready_mul", 64'(in_ready), 64'd0);
        wait_valid("max_lat");
        chk("max_prod", 64'(product), 64'hFFFE_FFFF_0001);
        chk("max_in_ready_done", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        chk("max_idle_valid", 64'(out_valid), 64'd0);
        chk("max_idle_busy",  64'(busy),      64'd0);

        run_op("shift", 16'h1234, 32'h0001_0000, 48'h0000_1234_0000);
        run_op("msb",   16'h8000, 32'h8000_0000, 48'h4000_0000_0000);
        run_op("zero",  16'h0000, 32'hDEAD_BEEF, 48'h0);
        run_op("small", 16'h0003, 32'h0000_0005, 48'hF);

        // Backpressure: the result must hold while out_ready is low.
        out_ready = 1'b0;
        issue(16'h00FF, 32'h0000_0100);
        wait_valid("bp_lat");
        repeat (5) begin
            chk("bp_valid",    64'(out_valid), 64'd1);
            chk("bp_prod",     64'(product),   64'hFF00);
            chk("bp_in_ready", 64'(in_ready),  64'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        chk("bp_taken_valid",    64'(out_valid), 64'd0);
        chk("bp_taken_in_ready", 64'(in_ready),  64'd1);

        // Back-to-back: in_valid held across three operand pairs.
        bm[0] = 16'h0002; bc[0] = 32'h0000_0003; be[0] = 48'h6;
        bm[1] = 16'hABCD; bc[1] = 32'h0000_1000; be[1] = 48'hABC_D000;
        bm[2] = 16'hFFFF; bc[2] = 32'h0001_0001; be[2] = 48'hFFFF_FFFF;
        in_valid = 1'b1; multiplier = bm[0]; multiplicand = bc[0];
        chk("b2b_rdy0", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        multiplier = bm[1]; multiplicand = bc[1];
        for (int i = 0; i < 3; i++) begin
            wait_valid("b2b_lat");
            chk("b2b_prod", 64'(product), 64'(be[i]));
            chk("b2b_in_ready", 64'(in_ready), 64'd1);
            @(posedge clk); #1;
            chk("b2b_busy_after", 64'(busy), (i < 2) ? 64'd1 : 64'd0);
            if (i == 0) begin
                multiplier = bm[2]; multiplicand = bc[2];
            end else if (i == 1) begin
                in_valid = 1'b0;
            end
        end

        // Asynchronous reset after one chunk has been accumulated.
        issue(16'h1111, 32'h2222_2222);
        @(posedge clk); #1;
        chk("pre_rst_busy", 64'(busy), 64'd1);
        rstn = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_busy",      64'(busy),      64'd0);
        chk("midrst_in_ready",  64'(in_ready),  64'd1);
        chk("midrst_product",   64'(product),   64'd0);
        rstn = 1'b1;
        @(posedge clk); #1;
        run_op("post_rst", 16'h0003, 32'h0000_0005, 48'hF);

        // Random operands with random output stalls.
        for (int t = 0; t < 300; t++) begin
            logic [MW-1:0] rm;
            logic [W-1:0]  rc;
            logic [63:0]   rexp;
            int            stall;
            rm    = MW'($urandom);
            rc    = W'($urandom);
            rexp  = 64'(rm) * 64'(rc);
            stall = $urandom_range(0, 3);
            out_ready = (stall == 0);
            issue(rm, rc);
            wait_valid("rnd_lat");
            repeat (stall) begin
                @(posedge clk); #1;
            end
            chk("rnd_valid", 64'(out_valid), 64'd1);
            chk("rnd_prod",  64'(product),   rexp);
            out_ready = 1'b1;
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
